// File: rtl/bitstream_receiver_if.sv
// Handshake/data bundle between a frame consumer and bitstream_receiver.
// The master side arms the receiver and owns the serial line; the slave is the receiver.
interface bitstream_receiver_if #(
    parameter int unsigned DATALEN = 64,
    parameter int unsigned CNTLEN  = 8
);
    logic               arm;
    logic               in;
    logic [DATALEN-1:0] dataout;
    logic [CNTLEN-1:0]  delay_cnt;
    logic               valid;
    logic               err;
    logic               busy;

    modport master (
        output arm,
        output in,
        input  dataout,
        input  delay_cnt,
        input  valid,
        input  err,
        input  busy
    );

    modport slave (
        input  arm,
        input  in,
        output dataout,
        output delay_cnt,
        output valid,
        output err,
        output busy
    );
endinterface

// File: rtl/bitstream_receiver.sv
// Decodes a two-frequency square-wave bit stream into a DATALEN-bit word and
// measures the delay from arm acceptance to the first rising edge.
module bitstream_receiver #(
    parameter int unsigned DATALEN  = 64,
    parameter int unsigned CNTLEN   = 8,
    parameter int unsigned CLK_DIV1 = 16,
    parameter int unsigned CLK_DIV2 = 32,
    parameter int unsigned TOL      = 2
) (
    input logic                clk,
    input logic                rst,
    bitstream_receiver_if.slave rx
);
    localparam int H1   = int'(CLK_DIV1 / 2);
    localparam int H2   = int'(CLK_DIV2 / 2);
    localparam int TOLI = int'(TOL);
    localparam int WW   = $clog2(H2 + TOLI + 2);
    localparam int BW   = $clog2(DATALEN + 1);

    if (H2 - H1 <= 2 * TOLI) begin : g_chk_bands
        $error("bitstream_receiver: CLK_DIV1/CLK_DIV2 half-period bands overlap");
    end
    if (H1 <= TOLI) begin : g_chk_tol
        $error("bitstream_receiver: CLK_DIV1/2 must exceed TOL");
    end

    localparam logic [WW:0] B1_LO = (WW+1)'(H1 - TOLI);
    localparam logic [WW:0] B1_HI = (WW+1)'(H1 + TOLI);
    localparam logic [WW:0] B0_LO = (WW+1)'(H2 - TOLI);
    localparam logic [WW:0] B0_HI = (WW+1)'(H2 + TOLI);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_HIGH,
        S_LOW,
        S_DONE,
        S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [WW-1:0]        r_width;
    logic [BW-1:0]        r_bitcnt;
    logic [DATALEN-1:0]   r_shift;
    logic [CNTLEN-1:0]    r_delay;
    logic [DATALEN-1:0]   r_dataout;
    logic [CNTLEN-1:0]    r_delay_out;

    logic                 w_rise;
    logic                 w_fall;
    logic [WW:0]          w_wcnt;
    logic                 w_band1;
    logic                 w_band0;
    logic                 w_last;
    logic                 w_frame_clr;
    logic                 w_delay_inc;
    logic                 w_width_clr;
    logic                 w_width_inc;
    logic                 w_shift_en;
    logic                 w_bit;
    logic                 w_load_out;
    logic [DATALEN-1:0]   w_shift_nxt;

    assign w_rise      = r_sync2 & ~r_prev;
    assign w_fall      = ~r_sync2 & r_prev;
    // Count includes the current cycle so the classified width equals the level length.
    assign w_wcnt      = {1'b0, r_width} + 1'b1;
    assign w_band1     = (w_wcnt >= B1_LO) && (w_wcnt <= B1_HI);
    assign w_band0     = (w_wcnt >= B0_LO) && (w_wcnt <= B0_HI);
    assign w_last      = (r_bitcnt == BW'(DATALEN - 1));
    assign w_shift_nxt = {r_shift[DATALEN-2:0], w_bit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_frame_clr  = 1'b0;
        w_delay_inc  = 1'b0;
        w_width_clr  = 1'b0;
        w_width_inc  = 1'b0;
        w_shift_en   = 1'b0;
        w_bit        = 1'b0;
        w_load_out   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rx.arm) begin
                    w_next_state = S_ARMED;
                    w_frame_clr  = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_rise) begin
                    w_next_state = S_HIGH;
                    w_width_clr  = 1'b1;
                end else begin
                    w_delay_inc = 1'b1;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    if (w_band1 || w_band0) begin
                        w_shift_en  = 1'b1;
                        w_bit       = w_band1;
                        w_width_clr = 1'b1;
                        if (w_last) begin
                            w_next_state = S_DONE;
                            w_load_out   = 1'b1;
                        end else begin
                            w_next_state = S_LOW;
                        end
                    end else begin
                        w_next_state = S_ERR;
                    end
                end else if (w_wcnt > B0_HI) begin
                    w_next_state = S_ERR;
                end else begin
                    w_width_inc = 1'b1;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    if (w_band1 || w_band0) begin
                        w_next_state = S_HIGH;
                        w_width_clr  = 1'b1;
                    end else begin
                        w_next_state = S_ERR;
                    end
                end else if (w_wcnt > B0_HI) begin
                    w_next_state = S_ERR;
                end else begin
                    w_width_inc = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_prev      <= 1'b0;
            r_width     <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_delay     <= '0;
            r_dataout   <= '0;
            r_delay_out <= '0;
        end else begin
            r_sync1 <= rx.in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;

            if (w_frame_clr) begin
                r_delay  <= '0;
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_delay_inc && (r_delay != '1)) begin
                r_delay <= r_delay + 1'b1;
            end

            if (w_width_clr) begin
                r_width <= '0;
            end else if (w_width_inc) begin
                r_width <= r_width + 1'b1;
            end

            if (w_shift_en) begin
                r_shift  <= w_shift_nxt;
                r_bitcnt <= r_bitcnt + 1'b1;
            end

            // Outputs load on entry to DONE so they are stable during the valid cycle.
            if (w_load_out) begin
                r_dataout   <= w_shift_nxt;
                r_delay_out <= r_delay;
            end
        end
    end

    assign rx.dataout   = r_dataout;
    assign rx.delay_cnt = r_delay_out;
    assign rx.valid     = (r_state == S_DONE);
    assign rx.err       = (r_state == S_ERR);
    assign rx.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_bitstream_receiver.sv
// Directed bench for bitstream_receiver: hand-computed words and delays for
// good frames, tolerance bands, stuck line, delay saturation, re-arm and reset.
module tb_bitstream_receiver;
    logic clk = 1'b0;
    logic rst = 1'b0;

    bitstream_receiver_if #(.DATALEN(64), .CNTLEN(8)) rx ();

    bitstream_receiver #(
        .DATALEN (64),
        .CNTLEN  (8),
        .CLK_DIV1(16),
        .CLK_DIV2(32),
        .TOL     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_valid = 0;
    int          n_err   = 0;
    logic [63:0] cap_data = '0;
    logic [7:0]  cap_delay = '0;

    always @(negedge clk) begin
        if (rx.valid) begin
            n_valid   <= n_valid + 1;
            cap_data  <= rx.dataout;
            cap_delay <= rx.delay_cnt;
        end
        if (rx.err) n_err <= n_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bit: line high for hi cycles then low for lo cycles, optional arm pulse at its start.
    task automatic send_bit_w(input int hi, input int lo, input logic pulse_arm);
        rx.in  = 1'b1;
        rx.arm = pulse_arm;
        @(negedge clk);
        rx.arm = 1'b0;
        repeat (hi - 1) @(negedge clk);
        rx.in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_word(input logic [63:0] w, input int arm_at);
        for (int i = 0; i < 64; i++) begin
            if (w[63-i]) send_bit_w(8, 8, (i == arm_at));
            else         send_bit_w(16, 16, (i == arm_at));
        end
    endtask

    // Accepted at the posedge between the two negedges; line then idles phase cycles.
    task automatic do_arm(input int phase);
        @(negedge clk);
        rx.arm = 1'b1;
        @(negedge clk);
        rx.arm = 1'b0;
        repeat (phase) @(negedge clk);
    endtask

    int v0, e0, hit;

    initial begin
        rx.arm = 1'b0;
        rx.in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dataout", rx.dataout, 64'h0);
        chk("rst_delay",   {56'h0, rx.delay_cnt}, 64'h0);
        chk("rst_flags",   {61'h0, rx.valid, rx.err, rx.busy}, 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame: zeros then 111000110101000, phase 3 -> delay 3+2
        v0 = n_valid;
        do_arm(3);
        chk("arm_busy", {63'h0, rx.busy}, 64'h1);
        send_word(64'h0000_0000_0000_71A8, -1);
        repeat (4) @(negedge clk);
        chk("good_nvalid", 64'(n_valid - v0), 64'd1);
        chk("good_data",   cap_data, 64'h0000_0000_0000_71A8);
        chk("good_delay",  {56'h0, cap_delay}, 64'd5);
        chk("good_idle",   {63'h0, rx.busy}, 64'h0);

        // Tolerance edges: 60 ones then highs 6,10,14,18 -> 1,1,0,0
        v0 = n_valid;
        do_arm(0);
        for (int i = 0; i < 60; i++) send_bit_w(8, 8, 1'b0);
        send_bit_w(6, 8, 1'b0);
        send_bit_w(10, 8, 1'b0);
        send_bit_w(14, 16, 1'b0);
        send_bit_w(18, 16, 1'b0);
        repeat (4) @(negedge clk);
        chk("tol_nvalid", 64'(n_valid - v0), 64'd1);
        chk("tol_data",   cap_data, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("tol_delay",  {56'h0, cap_delay}, 64'd2);

        // High half of 5 cycles: too short for either band
        v0 = n_valid; e0 = n_err;
        do_arm(2);
        send_bit_w(5, 8, 1'b0);
        chk("short_err",   64'(n_err - e0), 64'd1);
        chk("short_novld", 64'(n_valid - v0), 64'd0);
        chk("short_keep",  rx.dataout, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("short_idle",  {63'h0, rx.busy}, 64'h0);

        // High half of 19 cycles: beyond the 0 band
        e0 = n_err;
        do_arm(2);
        send_bit_w(8, 8, 1'b0);
        send_bit_w(19, 8, 1'b0);
        chk("long_err",  64'(n_err - e0), 64'd1);
        chk("long_keep", rx.dataout, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("long_dly",  {56'h0, rx.delay_cnt}, 64'd2);

        // Stuck high: 2 sync + 1 detect cycles, then W counts 1..18, ERR on the 22nd edge
        e0 = n_err;
        do_arm(1);
        rx.in = 1'b1;
        hit = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rx.err && hit < 0) hit = i;
        end
        chk("stuck_cycle", 64'(hit), 64'd22);
        chk("stuck_nerr",  64'(n_err - e0), 64'd1);
        chk("stuck_idle",  {63'h0, rx.busy}, 64'h0);
        rx.in = 1'b0;
        repeat (4) @(negedge clk);

        // Delay saturation
        v0 = n_valid;
        do_arm(300);
        send_word(64'hFFFF_FFFF_FFFF_FFFF, -1);
        repeat (4) @(negedge clk);
        chk("sat_nvalid", 64'(n_valid - v0), 64'd1);
        chk("sat_delay",  {56'h0, cap_delay}, 64'd255);
        chk("sat_data",   cap_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // Arm pulsed during bit 20 is ignored while busy
        v0 = n_valid;
        do_arm(4);
        send_word(64'hA5C3_0F1E_8421_7BDE, 20);
        repeat (4) @(negedge clk);
        chk("rearm_nvalid", 64'(n_valid - v0), 64'd1);
        chk("rearm_data",   cap_data, 64'hA5C3_0F1E_8421_7BDE);
        chk("rearm_delay",  {56'h0, cap_delay}, 64'd6);

        // Reset mid-frame clears outputs without an err pulse
        e0 = n_err;
        do_arm(1);
        for (int i = 0; i < 10; i++) send_bit_w(8, 8, 1'b0);
        rx.in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_dataout", rx.dataout, 64'h0);
        chk("mrst_delay",   {56'h0, rx.delay_cnt}, 64'h0);
        chk("mrst_flags",   {61'h0, rx.valid, rx.err, rx.busy}, 64'h0);
        rx.in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_noerr", 64'(n_err - e0), 64'd0);

        v0 = n_valid;
        do_arm(1);
        send_word(64'h0123_4567_89AB_CDEF, -1);
        repeat (4) @(negedge clk);
        chk("post_nvalid", 64'(n_valid - v0), 64'd1);
        chk("post_data",   cap_data, 64'h0123_4567_89AB_CDEF);
        chk("post_delay",  {56'h0, cap_delay}, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bitstream_receiver.md
# bitstream_receiver

Receive side of the antenna-modulation bit stream: recovers a DATALEN-bit word from the two-frequency square-wave stream produced by `bitstreamer`. Each data bit arrives as one high half-period followed by one low half-period. A 1 uses clock-division CLK_DIV1 and a 0 uses CLK_DIV2. The block sits on the demodulated/looped-back line, presents the decoded word with a one-cycle valid pulse, and reports the measured start delay, which corresponds to the transmitter's `phase_delay`.

## Interface
- `DATALEN`, 64: bits per frame.
- `CNTLEN`, 8: width of the start-delay counter.
- `CLK_DIV1`, 16: period in clk cycles of a 1 bit; its high half is CLK_DIV1/2.
- `CLK_DIV2`, 32: period in clk cycles of a 0 bit; its high half is CLK_DIV2/2.
- `TOL`, 2: allowed ± deviation, in clk cycles, of any measured half-period.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `arm`  in  1  one-cycle request to receive one frame; honoured only in IDLE.
- `in`  in  1  asynchronous serial stream.
- `dataout`  out  DATALEN  last good frame; first received bit lands in bit DATALEN-1.
- `delay_cnt`  out  CNTLEN  clk cycles from arm acceptance to first detected rising edge, saturating.
- `valid`  out  1  one-cycle pulse when `dataout`/`delay_cnt` are updated.
- `err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input path:
  - `in` passes through a 2-FF synchronizer and an edge-detect register.
  - Edges are evaluated on the synchronized signal `s`.
- Elaboration-time checks (error if violated):
  - CLK_DIV2/2 − CLK_DIV1/2 > 2·TOL.
  - CLK_DIV1/2 > TOL.
- States:
  - IDLE → ARMED on `arm`. The delay counter clears to 0, the bit counter clears, and the shift register clears.
  - ARMED: the delay counter increments each cycle, saturating at 2^CNTLEN−1. A rising edge of `s` moves to HIGH and freezes the delay value; the width counter is set to 0.
  - HIGH: the width counter W increments each cycle.
    - On a falling edge, W is classified:
      - |W − CLK_DIV1/2| ≤ TOL → bit 1.
      - |W − CLK_DIV2/2| ≤ TOL → bit 0.
      - Otherwise → ERR.
    - The decoded bit is shifted in at the LSB with a left shift, the bit counter increments, and the width counter is set to 0.
    - If this was bit DATALEN → DONE; otherwise → LOW.
    - If W exceeds CLK_DIV2/2+TOL before the falling edge → ERR immediately.
  - LOW: the width counter increments each cycle.
    - A rising edge with W within either band → HIGH, counter set to 0.
    - A rising edge outside both bands, or W exceeding CLK_DIV2/2+TOL → ERR.
  - DONE: the shift register is copied to `dataout`, the delay is copied to `delay_cnt`, and `valid` = 1. Next state is IDLE.
  - ERR: `err` = 1. `dataout` and `delay_cnt` keep their previous values. Next state is IDLE.
- ARMED has no timeout. A new `arm` aborts nothing: it is ignored while `busy`.
- Width counter width is clog2(CLK_DIV2/2+TOL+2).

## Timing
- Pin-to-edge-detect latency is 3 clk cycles; widths are exact because both edges carry the same latency.
- `valid` asserts on the cycle after the falling-edge detect of bit DATALEN, i.e. 4 cycles after the pin falls.
- `busy` rises the cycle after `arm`. It falls together with the `valid`/`err` cycle: IDLE is entered on the following edge.
- `arm` with a simultaneous `in` edge: the edge is not counted as the start, because ARMED has not yet been entered.
- Reset value of every output is 0, and all states return to IDLE. Reset mid-frame discards the partial word; no `err` pulse is issued.
- The frame ends at the last falling edge; the trailing low level is not checked.

## Test plan
- Frame good: 15-bit pattern 111000110101000 MSB-first, transmitter `phase_delay` 3, stream of 64 bits as zeros then pattern.
  - Required: one `valid` pulse, `dataout`=64'h0000_0000_0000_71A8, and `delay_cnt` equal to the arm-to-first-edge cycles.
- Tolerance edges: high halves of 6, 10, 14 and 18 cycles decode to 1,1,0,0. High halves of 5 and 19 cycles produce `err` at the offending edge, with `dataout` unchanged.
- Stuck line: line held high for 19 cycles after a rising edge.
  - Required: `err` pulse on the cycle W reaches 19, then IDLE, `busy`=0.
- Delay saturation: no edge for 300 cycles after `arm`, then a valid frame.
  - Required: `delay_cnt`=255.
- Re-arm and reset: `arm` pulsed mid-frame has no effect on the decoded word. `rst` low mid-frame forces all outputs to 0. A following full frame decodes correctly.
